spart_driver: RTL and testbench
===============================

// Module: spart_driver
// PURPOSE
//  Bus-master stage directly upstream of the SPART. It drives the SPART processor-side interface
//  (iocs/iorw/ioaddr/databus) and runs a Moore FSM with three jobs:
//  - programs the baud divisor from the board br_cfg switches after reset;
//  - reprograms the divisor whenever br_cfg changes;
//  - echoes every received byte back out (poll rda, read RX buffer, wait tbr, write TX buffer).
// PARAMETERS
//  CLK_HZ  50_000_000  system clock frequency in Hz; the divisor table is derived from it
// PORTS
//  clk      in     1  system clock, rising edge
//  rst      in     1  asynchronous, active-low reset
//  br_cfg   in     2  baud select: 00=4800, 01=9600, 10=19200, 11=38400
//  rda      in     1  SPART receive-data-available
//  tbr      in     1  SPART transmit-buffer-ready
//  iocs     out    1  SPART chip select
//  iorw     out    1  1=read from SPART, 0=write to SPART
//  ioaddr   out    2  00=TX/RX buffer, 01=status, 10=DB low, 11=DB high
//  databus  inout  8  shared data bus
//  rx_byte  out    8  last byte read from SPART
//  busy     out    1  high in any state other than IDLE
// BEHAVIOUR
//  Clock/reset: one clock, clk. rst is asynchronous and active-low.
//  Divisor: DIV = CLK_HZ/(16*baud) - 1, computed with integer division as a constant per br_cfg.
//   - At 50 MHz: 4800 -> 650 (0x028A), 9600 -> 324 (0x0144), 19200 -> 161 (0x00A1), 38400 -> 80 (0x0050).
//   - Width is 16 bits; the upper byte is zero when DIV < 256.
//  Reset values (rst=0, asynchronous):
//   - state=INIT, iocs=0, iorw=1, ioaddr=00, databus=Z;
//   - rx_byte=00, busy=1, cfg_q=00.
//  Outputs are decoded from the state register only (Moore), so every bus access lasts exactly one cycle.
//  databus is driven by this block only when iocs=1 and iorw=0; it is Z otherwise.
//  States, with output set and transitions:
//   - INIT: iocs=0. Next cycle -> CFG_LO.
//   - CFG_LO: iocs=1, iorw=0, ioaddr=10, databus=DIV[7:0]. cfg_q<=br_cfg on this edge. -> CFG_HI.
//     DIV is computed from br_cfg as sampled in this cycle.
//   - CFG_HI: iocs=1, iorw=0, ioaddr=11, databus=DIV[15:8]. DIV comes from cfg_q. -> IDLE.
//   - IDLE: iocs=0, busy=0.
//     - br_cfg!=cfg_q -> CFG_LO. Reconfiguration wins over a simultaneous rda=1.
//     - else rda=1 -> RX_READ.
//     - else stay in IDLE.
//   - RX_READ: iocs=1, iorw=1, ioaddr=00. rx_byte<=databus on the closing edge. -> TX_WAIT.
//   - TX_WAIT: iocs=0. tbr=1 -> TX_WRITE, else stay. Waits indefinitely; rda is ignored here.
//   - TX_WRITE: iocs=1, iorw=0, ioaddr=00, databus=rx_byte. -> IDLE.
//  Latency:
//   - Reset release to first divisor write: 1 cycle (INIT).
//   - Reset release to IDLE: 3 cycles.
//   - rda rise in IDLE to the RX read cycle: 1 cycle.
//   - tbr=1 in TX_WAIT to the TX write cycle: 1 cycle.
//  Boundary conditions:
//   - br_cfg change mid-echo: the echo completes, then reconfiguration runs from IDLE. No byte is dropped.
//   - rda still high in the first IDLE cycle after TX_WRITE: treated as a new byte. The SPART clears
//     rda on read, so the echo is not duplicated.
//   - br_cfg toggling every cycle: each IDLE visit compares against cfg_q; the last stable value wins.
//   - Reset asserted mid-access: iocs drops and databus goes Z immediately (asynchronously);
//     the FSM restarts at INIT.
//   - The status address (01) is never issued.
// TESTING
//  1. Reset, br_cfg=01, CLK_HZ=50M -> cycle1 INIT iocs=0; cycle2 addr10 data 0x44;
//     cycle3 addr11 data 0x01; cycle4 busy=0.
//  2. In IDLE, pulse rda with model databus=0x5A on read; tbr=1 -> one read cycle (addr00 iorw=1),
//     rx_byte=0x5A, next-but-one cycle write 0x5A (addr00 iorw=0).
//  3. Same as test 2 with tbr=0 for 20 cycles -> iocs=0 throughout the wait;
//     write 0x5A occurs 1 cycle after tbr rises.
//  4. br_cfg 01->11 while in TX_WAIT -> echo completes first, then writes 0x50 (addr10), 0x00 (addr11).
//  5. In IDLE, rda=1 and br_cfg changed 00->10 together -> writes 0xA1/0x00 first, then RX_READ.
//  6. Assert rst during TX_WRITE -> iocs=0 and databus=Z with no clock edge; after release,
//     CFG sequence repeats with the current br_cfg.

Source files
------------

// File: rtl/spart_driver.sv
`default_nettype none
// ============================================================================
// Module  : spart_driver
// Brief   : SPART bus master that programs the baud divisor and echoes RX bytes
// Revision: 1.0
// ============================================================================
module spart_driver #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] rx_byte,
  output logic       busy
);

  localparam logic [15:0] c_DIV_4800  = 16'(CLK_HZ / (16 * 4800)  - 1);
  localparam logic [15:0] c_DIV_9600  = 16'(CLK_HZ / (16 * 9600)  - 1);
  localparam logic [15:0] c_DIV_19200 = 16'(CLK_HZ / (16 * 19200) - 1);
  localparam logic [15:0] c_DIV_38400 = 16'(CLK_HZ / (16 * 38400) - 1);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_CFG_LO   = 3'd1,
    S_CFG_HI   = 3'd2,
    S_IDLE     = 3'd3,
    S_RX_READ  = 3'd4,
    S_TX_WAIT  = 3'd5,
    S_TX_WRITE = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cfg_q, cfg_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic [15:0] div_live;
  logic [15:0] div_held;

  function automatic logic [15:0] div_for(input logic [1:0] sel);
    case (sel)
      2'b00:   return c_DIV_4800;
      2'b01:   return c_DIV_9600;
      2'b10:   return c_DIV_19200;
      default: return c_DIV_38400;
    endcase
  endfunction

  // Low byte uses the live switches; high byte uses the value latched alongside it
  assign div_live = div_for(br_cfg);
  assign div_held = div_for(cfg_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_INIT;
      cfg_q     <= 2'b00;
      rx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      rx_byte_q <= rx_byte_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    rx_byte_d = rx_byte_q;
    iocs      = 1'b0;
    iorw      = 1'b1;
    ioaddr    = 2'b00;
    bus_out   = 8'h00;
    case (state_q)
      S_INIT: state_d = S_CFG_LO;
      S_CFG_LO: begin
        iocs    = 1'b1;
        iorw    = 1'b0;
        ioaddr  = 2'b10;
        bus_out = div_live[7:0];
        cfg_d   = br_cfg;
        state_d = S_CFG_HI;
      end
      S_CFG_HI: begin
        iocs    = 1'b1;
        iorw    = 1'b0;
        ioaddr  = 2'b11;
        bus_out = div_held[15:8];
        state_d = S_IDLE;
      end
      S_IDLE: begin
        // A pending reconfiguration takes priority over a waiting byte
        if (br_cfg != cfg_q) state_d = S_CFG_LO;
        else if (rda)        state_d = S_RX_READ;
      end
      S_RX_READ: begin
        iocs      = 1'b1;
        iorw      = 1'b1;
        ioaddr    = 2'b00;
        rx_byte_d = databus;
        state_d   = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (tbr) state_d = S_TX_WRITE;
      end
      S_TX_WRITE: begin
        iocs    = 1'b1;
        iorw    = 1'b0;
        ioaddr  = 2'b00;
        bus_out = rx_byte_q;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign bus_oe  = iocs & ~iorw;
  assign databus = bus_oe ? bus_out : 8'hzz;
  assign rx_byte = rx_byte_q;
  assign busy    = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spart_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_spart_driver
// Brief   : Randomized transaction-level bench for spart_driver
// Revision: 1.0
// ============================================================================
module tb_spart_driver;

  localparam int CLK_HZ = 50_000_000;

  logic       clk;
  logic       rst;
  logic [1:0] br_cfg;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] rx_byte;
  logic       busy;
  logic [7:0] spart_rx;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] m_cfg;
  int baud_tab [4] = '{4800, 9600, 19200, 38400};

  spart_driver #(.CLK_HZ(CLK_HZ)) dut (
    .clk     (clk),
    .rst     (rst),
    .br_cfg  (br_cfg),
    .rda     (rda),
    .tbr     (tbr),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rx_byte (rx_byte),
    .busy    (busy)
  );

  // SPART side: presents the RX buffer on a read of address 00
  assign databus = (iocs && iorw && ioaddr == 2'b00) ? spart_rx : 8'hzz;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] div_ref(input logic [1:0] cfg);
    return 16'(CLK_HZ / (16 * baud_tab[cfg]) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag, input logic exp_busy);
    chk({tag, "_bus"}, {23'd0, iocs, databus}, {23'd0, 1'b0, 8'hzz});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
  endtask

  task automatic chk_write(input string tag, input logic [1:0] addr, input logic [7:0] data);
    chk(tag, {20'd0, iocs, iorw, ioaddr, databus}, {20'd0, 1'b1, 1'b0, addr, data});
  endtask

  // Entered at the negedge of the low-byte divisor write; leaves at the first IDLE negedge
  task automatic cfg_seq(input string tag);
    logic [15:0] d;
    d = div_ref(br_cfg);
    chk_write({tag, "_lo"}, 2'b10, d[7:0]);
    m_cfg = br_cfg;
    step();
    chk_write({tag, "_hi"}, 2'b11, d[15:8]);
    chk({tag, "_hi_busy"}, {31'd0, busy}, 32'd1);
    step();
    chk_quiet({tag, "_idle"}, 1'b0);
  endtask

  task automatic reset_release(input string tag);
    @(negedge clk);
    rst = 1'b1;
    chk_quiet({tag, "_init"}, 1'b1);
    chk({tag, "_rxb"}, {24'd0, rx_byte}, 32'd0);
    step();
    cfg_seq(tag);
  endtask

  // cfg_mode: -1 leave br_cfg alone, -2 randomize it every wait cycle, else switch to that value
  task automatic echo(input string tag, input logic [7:0] b, input int dly, input int cfg_mode);
    spart_rx = b;
    rda      = 1'b1;
    step();
    chk({tag, "_rd"}, {28'd0, iocs, iorw, ioaddr}, {28'd0, 4'b1100});
    rda = 1'b0;
    tbr = 1'b0;
    step();
    chk({tag, "_rxb"}, {24'd0, rx_byte}, {24'd0, b});
    for (int i = 0; i < dly; i++) begin
      chk_quiet({tag, "_wait"}, 1'b1);
      rda = 1'($urandom_range(0, 1));
      if (cfg_mode == -2) br_cfg = 2'($urandom_range(0, 3));
      else if (cfg_mode >= 0) br_cfg = 2'(cfg_mode);
      step();
    end
    chk_quiet({tag, "_wait_end"}, 1'b1);
    if (cfg_mode >= 0) br_cfg = 2'(cfg_mode);
    rda = 1'b0;
    tbr = 1'b1;
    step();
    chk_write({tag, "_wr"}, 2'b00, b);
    tbr = 1'($urandom_range(0, 1));
    step();
    chk_quiet({tag, "_idle"}, 1'b0);
    if (br_cfg != m_cfg) begin
      step();
      cfg_seq({tag, "_recfg"});
    end
  endtask

  initial begin
    rst      = 1'b0;
    br_cfg   = 2'b01;
    rda      = 1'b0;
    tbr      = 1'b0;
    spart_rx = 8'h00;
    m_cfg    = 2'b00;
    #1;
    chk_quiet("rst", 1'b1);
    chk("rst_rxb", {24'd0, rx_byte}, 32'd0);

    reset_release("t1");
    echo("t2", 8'h5A, 0, -1);
    echo("t3", 8'h5A, 20, -1);
    echo("t4", 8'hA7, 3, 3);

    br_cfg = 2'b00;
    step();
    cfg_seq("t5_pre");
    br_cfg   = 2'b10;
    spart_rx = 8'h3C;
    rda      = 1'b1;
    step();
    cfg_seq("t5_cfg");
    echo("t5", 8'h3C, 1, -1);

    spart_rx = 8'hC3;
    rda      = 1'b1;
    step();
    rda = 1'b0;
    step();
    tbr = 1'b1;
    step();
    chk_write("t6_wr", 2'b00, 8'hC3);
    br_cfg = 2'b11;
    #2 rst = 1'b0;
    #1;
    chk_quiet("t6_async", 1'b1);
    reset_release("t6");

    for (int it = 0; it < 60; it++) begin
      logic [1:0] nc;
      logic [7:0] b;
      b  = 8'($urandom);
      nc = 2'(m_cfg + 2'($urandom_range(1, 3)));
      case ($urandom_range(0, 3))
        0: echo("r_echo", b, int'($urandom_range(0, 6)),
                ($urandom_range(0, 1) == 1) ? -2 : -1);
        1: begin
          br_cfg = nc;
          step();
          cfg_seq("r_cfg");
        end
        2: begin
          br_cfg   = nc;
          spart_rx = b;
          rda      = 1'b1;
          step();
          cfg_seq("r_both");
          echo("r_both", b, int'($urandom_range(0, 3)), -1);
        end
        default: begin
          rda = 1'b0;
          for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
            step();
            chk_quiet("r_idle", 1'b0);
          end
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
